axi4_mem_slave: RTL and testbench
=================================

# axi4_mem_slave

Synthesizable AXI4 full-protocol memory slave: the RTL successor to the behavioural slave model used in the AXI4 benches. Parametrised in data width, address width, ID width and memory depth. Supports FIXED, INCR and WRAP bursts up to 256 beats, byte strobes, narrow transfers and SLVERR reporting. Sits on an `axi4_if` slave port, driven by the master BFM in benches or by a DMA/CPU master in designs.

## Interface
- DATA_BYTES, 4, data bus width in bytes (power of two, 1..64)
- ADDR_BYTES, 2, address bus width in bytes
- NUM_ID_BITS, 4, width of awid/bid/arid/rid
- DEPTH_WORDS, 256, memory depth in DATA_BYTES-wide words (power of two)
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awvalid/awready  in/out  1/1  write address handshake
- awaddr  in  ADDR_BYTES*8  burst start byte address
- awlen, awsize, awburst, awid  in  8, 3, 2, NUM_ID_BITS  burst length-1, log2 bytes/beat, type, ID
- wvalid/wready, wlast  in/out, in  1/1, 1  write data handshake, final-beat marker
- wdata, wstrb  in  DATA_BYTES*8, DATA_BYTES  write data, byte enables
- bvalid/bready  out/in  1/1  write response handshake
- bresp, bid  out  2, NUM_ID_BITS  response code, echoed awid
- arvalid/arready  in/out  1/1  read address handshake
- araddr, arlen, arsize, arburst, arid  in  as aw*  read burst attributes
- rvalid/rready  out/in  1/1  read data handshake
- rdata, rresp, rid, rlast  out  DATA_BYTES*8, 2, NUM_ID_BITS, 1  read beat data, response, echoed arid, final beat
- aw/ar cache, prot, lock, region, qos, user and wuser  in  per axi4_if  accepted, ignored; buser/ruser driven 0

## Operation
- Write FSM: W_IDLE (awready=1) -> on AW handshake latch addr/len/size/burst/id, go W_DATA (wready=1) -> each W handshake writes bytes with wstrb=1, advances address -> after beat awlen accepted go W_RESP (bvalid=1) -> on bready go W_IDLE.
- Read FSM: R_IDLE (arready=1) -> on AR handshake latch attributes, go R_DATA -> beats presented in order, rlast on beat arlen -> on final R handshake go R_IDLE.
- Write and read FSMs fully independent; one outstanding burst per direction.
- Address update per beat: FIXED unchanged; INCR += 2^size; WRAP += 2^size, wrapping within (awlen+1)*2^size-aligned window. First beat uses start address aligned down to 2^size.
- Word index = addr[log2(DATA_BYTES)+log2(DEPTH_WORDS)-1 : log2(DATA_BYTES)]; address bits above that nonzero = out of range.
- Error (SLVERR=2'b10), burst still completes with full beat count:
  - burst=2'b11, size > log2(DATA_BYTES), or WRAP with len not in {1,3,7,15}: whole burst errors, no memory access.
  - out-of-range beat: write beat discarded / read beat rdata=0, that beat errors.
  - bresp=SLVERR if any beat errored, else OKAY. rresp per beat.
- wlast ignored for counting; awlen governs burst end. wlast mismatch does not error.
- Reads return full word; byte-lane selection is the master's job.
- Same-word write and read in one cycle: read returns pre-write data.

## Timing
- Reset: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0; FSMs to idle. Memory contents not reset.
- First cycle after areset deasserts: awready=arready=1.
- AW handshake cycle N -> wready=1 from N+1; W beats one per cycle at full rate.
- Final W handshake cycle M -> bvalid=1 at M+1; awready=1 the cycle after B handshake.
- AR handshake cycle N -> first rvalid at N+1 (registered memory read); subsequent beats back-to-back while rready=1.
- rvalid/rdata/rresp/rlast/rid held stable while rready=0; bvalid/bresp/bid held stable while bready=0.
- Reset mid-burst: burst abandoned, no response issued; partial writes already performed remain.

## Test plan
- INCR write awaddr=0x10, awlen=3, wdata 0x11111111..0x44444444, wstrb=0xF, then INCR read same -> 4 beats return identical data, rlast only on beat 4, bresp=rresp=OKAY, bid/rid echo IDs.
- WRAP read araddr=0x38, arlen=3, size=2 after filling words 0x30..0x3C with index -> beat order 0x38, 0x3C, 0x30, 0x34.
- Write 0xAABBCCDD wstrb=0x5 over 0x00000000 -> readback 0x00BB00DD; FIXED write awlen=2 -> only last beat data persists.
- awaddr beyond DEPTH_WORDS*DATA_BYTES, or awburst=2'b11 -> all beats accepted, bresp=SLVERR, memory unchanged; read of such region -> rresp=SLVERR, rdata=0.
- Random rready/bready throttling with concurrent read and write bursts -> no lost/duplicated beats, outputs stable while stalled.
- Assert areset during a write at beat 2 of 4 -> all valids/readys 0 during reset, awready=1 after release, no bvalid for abandoned burst.

Source files
------------

// File: rtl/axi4_mem_slave.sv
// AXI4 memory slave: single-ported word array behind independent write and
// read burst engines. FIXED/INCR/WRAP bursts, byte strobes, SLVERR reporting.
module axi4_mem_slave #(
   parameter int DATA_BYTES  = 4,
   parameter int ADDR_BYTES  = 2,
   parameter int NUM_ID_BITS = 4,
   parameter int DEPTH_WORDS = 256
) (
   input  logic                      i_aclk,
   input  logic                      i_areset,
   input  logic                      i_awvalid,
   output logic                      o_awready,
   input  logic [ADDR_BYTES*8-1:0]   i_awaddr,
   input  logic [7:0]                i_awlen,
   input  logic [2:0]                i_awsize,
   input  logic [1:0]                i_awburst,
   input  logic [NUM_ID_BITS-1:0]    i_awid,
   input  logic [3:0]                i_awcache,
   input  logic [2:0]                i_awprot,
   input  logic                      i_awlock,
   input  logic [3:0]                i_awregion,
   input  logic [3:0]                i_awqos,
   input  logic                      i_awuser,
   input  logic                      i_wvalid,
   output logic                      o_wready,
   input  logic                      i_wlast,
   input  logic [DATA_BYTES*8-1:0]   i_wdata,
   input  logic [DATA_BYTES-1:0]     i_wstrb,
   input  logic                      i_wuser,
   output logic                      o_bvalid,
   input  logic                      i_bready,
   output logic [1:0]                o_bresp,
   output logic [NUM_ID_BITS-1:0]    o_bid,
   output logic                      o_buser,
   input  logic                      i_arvalid,
   output logic                      o_arready,
   input  logic [ADDR_BYTES*8-1:0]   i_araddr,
   input  logic [7:0]                i_arlen,
   input  logic [2:0]                i_arsize,
   input  logic [1:0]                i_arburst,
   input  logic [NUM_ID_BITS-1:0]    i_arid,
   input  logic [3:0]                i_arcache,
   input  logic [2:0]                i_arprot,
   input  logic                      i_arlock,
   input  logic [3:0]                i_arregion,
   input  logic [3:0]                i_arqos,
   input  logic                      i_aruser,
   output logic                      o_rvalid,
   input  logic                      i_rready,
   output logic [DATA_BYTES*8-1:0]   o_rdata,
   output logic [1:0]                o_rresp,
   output logic [NUM_ID_BITS-1:0]    o_rid,
   output logic                      o_rlast,
   output logic                      o_ruser
);
   localparam int DW   = DATA_BYTES * 8;
   localparam int AW   = ADDR_BYTES * 8;
   localparam int OFFB = $clog2(DATA_BYTES);
   localparam int IDXB = $clog2(DEPTH_WORDS);

   localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
   localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00, BURST_WRAP = 2'b10;

   // Start address rounded down to the beat size.
   function automatic logic [AW-1:0] f_align(input logic [AW-1:0] addr, input logic [2:0] size);
      return addr & ~((AW'(1) << size) - AW'(1));
   endfunction

   // Address of the beat following addr; WRAP stays inside its (len+1)*2^size window.
   function automatic logic [AW-1:0] f_next(input logic [AW-1:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
      logic [AW-1:0] incr;
      logic [AW-1:0] mask;
      incr = AW'(1) << size;
      mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
      case (burst)
         BURST_FIXED: return addr;
         BURST_WRAP:  return (addr & ~mask) | ((addr + incr) & mask);
         default:     return addr + incr;
      endcase
   endfunction

   // Attributes that poison the whole burst: reserved type, oversize beat, illegal wrap length.
   function automatic logic f_attr_err(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      return (burst == 2'b11) || (size > 3'(OFFB)) ||
             ((burst == BURST_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
   endfunction

   // Any address bit above the word index set means the beat falls outside the array.
   function automatic logic f_oor(input logic [AW-1:0] addr);
      return (addr >> (OFFB + IDXB)) != '0;
   endfunction

   logic [DW-1:0]          r_mem [DEPTH_WORDS];

   logic [1:0]             r_wstate;
   logic                   r_awready, r_wready, r_bvalid;
   logic [1:0]             r_bresp;
   logic [NUM_ID_BITS-1:0] r_bid;
   logic [AW-1:0]          r_waddr;
   logic [7:0]             r_wlen, r_wcnt;
   logic [2:0]             r_wsize;
   logic [1:0]             r_wburst;
   logic                   r_wattr_err, r_werr_acc;

   logic [0:0]             r_rstate;
   logic                   r_arready, r_rvalid, r_rlast;
   logic [NUM_ID_BITS-1:0] r_rid;
   logic [AW-1:0]          r_raddr;
   logic [7:0]             r_rlen, r_rcnt;
   logic [2:0]             r_rsize;
   logic [1:0]             r_rburst;
   logic                   r_rattr_err;
   logic [DW-1:0]          r_rdata;
   logic [1:0]             r_rresp;

   logic                   w_w_hs, w_wbeat_err, w_wr_en;
   logic [IDXB-1:0]        w_wr_idx;
   logic [DATA_BYTES-1:0]  w_byte_we;
   logic                   w_ar_hs, w_r_hs, w_rd_en, w_rd_err;
   logic [AW-1:0]          w_rd_addr;
   logic [IDXB-1:0]        w_rd_idx;
   logic                   w_unused;

   assign w_unused = ^{i_awcache, i_awprot, i_awlock, i_awregion, i_awqos, i_awuser, i_wlast, i_wuser,
                       i_arcache, i_arprot, i_arlock, i_arregion, i_arqos, i_aruser};

   assign w_w_hs      = r_wready & i_wvalid;
   assign w_wbeat_err = r_wattr_err | f_oor(r_waddr);
   assign w_wr_en     = w_w_hs & ~w_wbeat_err;
   assign w_wr_idx    = r_waddr[OFFB +: IDXB];

   generate
      for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_byte_we
         assign w_byte_we[gi] = w_wr_en & i_wstrb[gi];
      end
   endgenerate

   // Read address for the next memory access: burst start on AR, else the following beat.
   assign w_ar_hs   = r_arready & i_arvalid;
   assign w_r_hs    = r_rvalid & i_rready;
   assign w_rd_en   = w_ar_hs | (w_r_hs & ~r_rlast);
   assign w_rd_addr = w_ar_hs ? f_align(i_araddr, i_arsize) : f_next(r_raddr, r_rsize, r_rlen, r_rburst);
   assign w_rd_err  = (w_ar_hs ? f_attr_err(i_arlen, i_arsize, i_arburst) : r_rattr_err) | f_oor(w_rd_addr);
   assign w_rd_idx  = w_rd_addr[OFFB +: IDXB];

   // Byte-enabled memory write; contents are deliberately not reset.
   always_ff @(posedge i_aclk) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
         if (w_byte_we[b]) r_mem[w_wr_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
   end

   // Registered memory read; errored beats return zero. Reads see pre-write data.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_rd_en) begin
         r_rdata <= w_rd_err ? '0 : r_mem[w_rd_idx];
         r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   // Write burst engine: accept AW, count awlen+1 beats, then hold B until bready.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_wstate <= W_IDLE;   r_awready <= 1'b0; r_wready <= 1'b0;  r_bvalid <= 1'b0;
         r_bresp <= RESP_OKAY; r_bid <= '0;       r_waddr <= '0;     r_wlen <= '0;
         r_wcnt <= '0;         r_wsize <= '0;     r_wburst <= '0;    r_wattr_err <= 1'b0;
         r_werr_acc <= 1'b0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               r_awready <= 1'b1;
               if (r_awready && i_awvalid) begin
                  r_awready   <= 1'b0;
                  r_wready    <= 1'b1;
                  r_waddr     <= f_align(i_awaddr, i_awsize);
                  r_wlen      <= i_awlen;
                  r_wsize     <= i_awsize;
                  r_wburst    <= i_awburst;
                  r_wattr_err <= f_attr_err(i_awlen, i_awsize, i_awburst);
                  r_bid       <= i_awid;
                  r_wcnt      <= '0;
                  r_werr_acc  <= 1'b0;
                  r_wstate    <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_w_hs) begin
                  r_waddr    <= f_next(r_waddr, r_wsize, r_wlen, r_wburst);
                  r_wcnt     <= r_wcnt + 8'd1;
                  r_werr_acc <= r_werr_acc | w_wbeat_err;
                  if (r_wcnt == r_wlen) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_werr_acc | w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
                     r_wstate <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (i_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // Read burst engine: accept AR, present beats in order, release after the rlast handshake.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_rstate <= R_IDLE; r_arready <= 1'b0; r_rvalid <= 1'b0; r_rlast <= 1'b0;
         r_rid <= '0;        r_raddr <= '0;     r_rlen <= '0;     r_rcnt <= '0;
         r_rsize <= '0;      r_rburst <= '0;    r_rattr_err <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               r_arready <= 1'b1;
               if (w_ar_hs) begin
                  r_arready   <= 1'b0;
                  r_rvalid    <= 1'b1;
                  r_rlast     <= (i_arlen == 8'd0);
                  r_rid       <= i_arid;
                  r_raddr     <= w_rd_addr;
                  r_rlen      <= i_arlen;
                  r_rsize     <= i_arsize;
                  r_rburst    <= i_arburst;
                  r_rattr_err <= f_attr_err(i_arlen, i_arsize, i_arburst);
                  r_rcnt      <= '0;
                  r_rstate    <= R_DATA;
               end
            end
            R_DATA: begin
               if (w_r_hs) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_rstate  <= R_IDLE;
                  end else begin
                     r_rcnt  <= r_rcnt + 8'd1;
                     r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                     r_raddr <= w_rd_addr;
                  end
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign o_awready = r_awready;
   assign o_wready  = r_wready;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_bresp;
   assign o_bid     = r_bid;
   assign o_buser   = 1'b0;
   assign o_arready = r_arready;
   assign o_rvalid  = r_rvalid;
   assign o_rdata   = r_rdata;
   assign o_rresp   = r_rresp;
   assign o_rid     = r_rid;
   assign o_rlast   = r_rlast;
   assign o_ruser   = 1'b0;
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Scoreboard bench for axi4_mem_slave: expected B/R traffic is queued when a
// burst is issued and compared as the slave delivers it.
module tb_axi4_mem_slave;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_areset;
   logic        i_awvalid, o_awready, i_wvalid, o_wready, i_wlast;
   logic [15:0] i_awaddr, i_araddr;
   logic [7:0]  i_awlen, i_arlen;
   logic [2:0]  i_awsize, i_arsize;
   logic [1:0]  i_awburst, i_arburst;
   logic [3:0]  i_awid, i_arid;
   logic [31:0] i_wdata;
   logic [3:0]  i_wstrb;
   logic        o_bvalid, i_bready, o_buser;
   logic [1:0]  o_bresp, o_rresp;
   logic [3:0]  o_bid, o_rid;
   logic        i_arvalid, o_arready, o_rvalid, i_rready, o_rlast, o_ruser;
   logic [31:0] o_rdata;

   axi4_mem_slave dut (
      .i_aclk(clk), .i_areset(i_areset),
      .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr), .i_awlen(i_awlen),
      .i_awsize(i_awsize), .i_awburst(i_awburst), .i_awid(i_awid),
      .i_awcache(4'd0), .i_awprot(3'd0), .i_awlock(1'b0), .i_awregion(4'd0), .i_awqos(4'd0), .i_awuser(1'b0),
      .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wlast(i_wlast), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
      .i_wuser(1'b0),
      .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp), .o_bid(o_bid), .o_buser(o_buser),
      .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr), .i_arlen(i_arlen),
      .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arid(i_arid),
      .i_arcache(4'd0), .i_arprot(3'd0), .i_arlock(1'b0), .i_arregion(4'd0), .i_arqos(4'd0), .i_aruser(1'b0),
      .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rid(o_rid),
      .o_rlast(o_rlast), .o_ruser(o_ruser)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rbeat_t;

   int          errors = 0;
   int          checks = 0;
   rbeat_t      rq[$];
   logic [5:0]  bq[$];
   logic [31:0] model[256];
   logic [31:0] wd[256];
   logic [3:0]  ws[256];
   bit          throttle = 1'b0;

   // Byte address of beat n of a burst, from the AXI burst rules.
   function automatic logic [15:0] beat_addr(input logic [15:0] start, input int n, input logic [2:0] size,
                                             input int len, input logic [1:0] burst);
      int nb, al, total, base;
      nb = 1 << size;
      al = (int'(start) / nb) * nb;
      case (burst)
         2'b00: return 16'(al);
         2'b10: begin
            total = (len + 1) * nb;
            base  = (al / total) * total;
            return 16'(base + ((al - base + n * nb) % total));
         end
         default: return 16'(al + n * nb);
      endcase
   endfunction

   function automatic bit attr_err(input int len, input logic [2:0] size, input logic [1:0] burst);
      return (burst == 2'b11) || (size > 3'd2) ||
             (burst == 2'b10 && len != 1 && len != 3 && len != 7 && len != 15);
   endfunction

   // B channel: random bready when throttled, stability while stalled, scoreboard pop.
   logic       b_prev_stall;
   logic [1:0] b_prev_resp;
   logic [3:0] b_prev_id;
   always @(negedge clk) begin
      if (i_areset) begin
         i_bready     = 1'b1;
         b_prev_stall = 1'b0;
      end else begin
         i_bready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         if (b_prev_stall) begin
            checks++;
            if (o_bvalid !== 1'b1 || o_bresp !== b_prev_resp || o_bid !== b_prev_id) begin
               errors++;
               $display("FAIL b_stable: got v=%b resp=%b id=%h, want v=1 resp=%b id=%h",
                        o_bvalid, o_bresp, o_bid, b_prev_resp, b_prev_id);
            end
         end
         if (o_bvalid && i_bready) begin
            checks++;
            if (bq.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected: got resp=%b id=%h, want no response", o_bresp, o_bid);
            end else begin
               logic [5:0] e;
               e = bq.pop_front();
               if ({o_bresp, o_bid} !== e) begin
                  errors++;
                  $display("FAIL b_resp: got resp=%b id=%h, want resp=%b id=%h", o_bresp, o_bid, e[5:4], e[3:0]);
               end
            end
         end
         b_prev_stall = o_bvalid && !i_bready;
         b_prev_resp  = o_bresp;
         b_prev_id    = o_bid;
      end
   end

   // R channel: same structure as B, comparing data/resp/last/id per beat.
   logic   r_prev_stall;
   rbeat_t r_prev;
   always @(negedge clk) begin
      if (i_areset) begin
         i_rready     = 1'b1;
         r_prev_stall = 1'b0;
      end else begin
         i_rready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         if (r_prev_stall) begin
            checks++;
            if (o_rvalid !== 1'b1 || o_rdata !== r_prev.data || o_rresp !== r_prev.resp ||
                o_rlast !== r_prev.last || o_rid !== r_prev.id) begin
               errors++;
               $display("FAIL r_stable: got v=%b d=%h resp=%b last=%b id=%h, want v=1 d=%h resp=%b last=%b id=%h",
                        o_rvalid, o_rdata, o_rresp, o_rlast, o_rid, r_prev.data, r_prev.resp, r_prev.last, r_prev.id);
            end
         end
         if (o_rvalid && i_rready) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL r_unexpected: got d=%h resp=%b, want no beat", o_rdata, o_rresp);
            end else begin
               rbeat_t e;
               e = rq.pop_front();
               if (o_rdata !== e.data || o_rresp !== e.resp || o_rlast !== e.last || o_rid !== e.id) begin
                  errors++;
                  $display("FAIL r_beat: got d=%h resp=%b last=%b id=%h, want d=%h resp=%b last=%b id=%h",
                           o_rdata, o_rresp, o_rlast, o_rid, e.data, e.resp, e.last, e.id);
               end
            end
         end
         r_prev_stall = o_rvalid && !i_rready;
         r_prev.data  = o_rdata;
         r_prev.resp  = o_rresp;
         r_prev.last  = o_rlast;
         r_prev.id    = o_rid;
      end
   end

   // Issue a write burst using wd[]/ws[]; updates the model and queues the expected B.
   task automatic do_write(input logic [15:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
      bit          err;
      bit          be;
      logic [15:0] a;
      int          n;
      err = 1'b0;
      for (int b = 0; b <= len; b++) begin
         a  = beat_addr(addr, b, size, len, burst);
         be = attr_err(len, size, burst) || (a >= 16'h0400);
         err |= be;
         if (!be) begin
            for (int k = 0; k < 4; k++)
               if (ws[b][k]) model[a[9:2]][k*8 +: 8] = wd[b][k*8 +: 8];
         end
      end
      bq.push_back({err ? 2'b10 : 2'b00, id});
      $display("write addr=%h len=%0d size=%0d burst=%0d id=%h", addr, len, size, burst, id);
      i_awaddr = addr; i_awlen = 8'(len); i_awsize = size; i_awburst = burst; i_awid = id; i_awvalid = 1'b1;
      n = 0;
      while (!o_awready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      i_awvalid = 1'b0;
      checks++;
      if (n >= 100 || o_wready !== 1'b1) begin
         errors++;
         $display("FAIL aw_accept: got wready=%b after %0d waits, want wready=1", o_wready, n);
      end
      for (int b = 0; b <= len; b++) begin
         i_wdata = wd[b]; i_wstrb = ws[b]; i_wlast = (b == len); i_wvalid = 1'b1;
         n = 0;
         while (!o_wready && n < 100) begin @(negedge clk); n++; end
         @(negedge clk);
         if (n >= 100) begin
            checks++; errors++;
            $display("FAIL w_timeout: got wready=0 on beat %0d, want 1", b);
         end
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
      n = 0;
      while (bq.size() != 0 && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL b_timeout: got %0d pending responses, want 0", bq.size());
      end
   endtask

   // Issue a read burst; expected beats come from the model at issue time.
   task automatic do_read(input logic [15:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
      rbeat_t      e;
      logic [15:0] a;
      int          n;
      for (int b = 0; b <= len; b++) begin
         a = beat_addr(addr, b, size, len, burst);
         if (attr_err(len, size, burst) || a >= 16'h0400) begin
            e.data = 32'h0; e.resp = 2'b10;
         end else begin
            e.data = model[a[9:2]]; e.resp = 2'b00;
         end
         e.last = (b == len);
         e.id   = id;
         rq.push_back(e);
      end
      $display("read  addr=%h len=%0d size=%0d burst=%0d id=%h", addr, len, size, burst, id);
      i_araddr = addr; i_arlen = 8'(len); i_arsize = size; i_arburst = burst; i_arid = id; i_arvalid = 1'b1;
      n = 0;
      while (!o_arready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      i_arvalid = 1'b0;
      checks++;
      if (n >= 100 || o_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL ar_latency: got rvalid=%b after %0d waits, want rvalid=1", o_rvalid, n);
      end
      n = 0;
      while (rq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) begin
         checks++; errors++;
         $display("FAIL r_timeout: got %0d pending beats, want 0", rq.size());
      end
   endtask

   task automatic test_reset();
      i_areset = 1'b1;
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0; i_wlast = 1'b0;
      i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awid = '0;
      i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arid = '0;
      i_wdata = '0; i_wstrb = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, want 000000",
                  {o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast});
      end
      checks++;
      if ({o_bresp, o_rresp, o_bid, o_rid, o_rdata} !== 44'h0) begin
         errors++;
         $display("FAIL reset_data: got bresp=%b rresp=%b bid=%h rid=%h rdata=%h, want all 0",
                  o_bresp, o_rresp, o_bid, o_rid, o_rdata);
      end
      i_areset = 1'b0;
      @(negedge clk);
      checks++;
      if (o_awready !== 1'b1 || o_arready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got awready=%b arready=%b, want 1 1", o_awready, o_arready);
      end
      $display("reset checked");
   endtask

   task automatic test_incr();
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h11111111 * (i + 1); ws[i] = 4'hF; end
      do_write(16'h0010, 3, 3'd2, 2'b01, 4'h5);
      do_read(16'h0010, 3, 3'd2, 2'b01, 4'h9);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h30 + 32'(4 * i); ws[i] = 4'hF; end
      do_write(16'h0030, 3, 3'd2, 2'b01, 4'h1);
      do_read(16'h0038, 3, 3'd2, 2'b10, 4'h2);
   endtask

   task automatic test_strobe_fixed();
      wd[0] = 32'h0; ws[0] = 4'hF;
      do_write(16'h0040, 0, 3'd2, 2'b01, 4'h3);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
      do_write(16'h0040, 0, 3'd2, 2'b01, 4'h3);
      do_read(16'h0040, 0, 3'd2, 2'b01, 4'h3);
      for (int i = 0; i < 3; i++) begin wd[i] = 32'hF0000001 + 32'(i); ws[i] = 4'hF; end
      do_write(16'h0044, 2, 3'd2, 2'b00, 4'hA);
      do_read(16'h0044, 0, 3'd2, 2'b01, 4'hA);
      wd[0] = 32'h0; ws[0] = 4'hF;
      do_write(16'h0048, 0, 3'd2, 2'b01, 4'h4);
      wd[0] = 32'h000000A1; ws[0] = 4'h1;
      wd[1] = 32'h0000B200; ws[1] = 4'h2;
      wd[2] = 32'h00C30000; ws[2] = 4'h4;
      wd[3] = 32'hD4000000; ws[3] = 4'h8;
      do_write(16'h0048, 3, 3'd0, 2'b01, 4'h4);
      do_read(16'h0048, 0, 3'd2, 2'b01, 4'h4);
   endtask

   task automatic test_errors();
      wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
      do_write(16'h0000, 1, 3'd2, 2'b01, 4'h1);
      wd[0] = 32'h55555555; wd[1] = 32'h66666666; wd[2] = 32'h77777777;
      do_write(16'h0400, 1, 3'd2, 2'b01, 4'h2);
      do_read(16'h0000, 1, 3'd2, 2'b01, 4'h3);
      do_read(16'h0400, 1, 3'd2, 2'b01, 4'h4);
      do_write(16'h0000, 1, 3'd2, 2'b11, 4'h5);
      do_write(16'h0000, 2, 3'd2, 2'b10, 4'h6);
      do_write(16'h0000, 1, 3'd3, 2'b01, 4'h7);
      do_read(16'h0000, 1, 3'd2, 2'b01, 4'h8);
      do_read(16'h0000, 1, 3'd2, 2'b11, 4'h9);
      wd[0] = 32'hCAFEF00D; wd[1] = 32'hDEADBEEF;
      do_write(16'h03FC, 1, 3'd2, 2'b01, 4'hB);
      do_read(16'h03FC, 1, 3'd2, 2'b01, 4'hC);
   endtask

   task automatic test_back_to_back();
      throttle = 1'b1;
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      fork
         do_write(16'h0100, 7, 3'd2, 2'b01, 4'hD);
         do_read(16'h0010, 3, 3'd2, 2'b01, 4'hE);
      join
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      fork
         do_write(16'h0200, 15, 3'd2, 2'b01, 4'h6);
         do_read(16'h0100, 7, 3'd2, 2'b01, 4'h7);
      join
      do_read(16'h0200, 15, 3'd2, 2'b01, 4'h8);
      do_read(16'h0108, 3, 3'd2, 2'b10, 4'h9);
      throttle = 1'b0;
   endtask

   task automatic test_reset_midburst();
      int n;
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hBEEF0000 + 32'(i); ws[i] = 4'hF; end
      $display("write addr=0080 len=3 interrupted by reset at beat 2");
      i_awaddr = 16'h0080; i_awlen = 8'd3; i_awsize = 3'd2; i_awburst = 2'b01; i_awid = 4'h7; i_awvalid = 1'b1;
      n = 0;
      while (!o_awready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      i_awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         i_wdata = wd[b]; i_wstrb = 4'hF; i_wvalid = 1'b1;
         n = 0;
         while (!o_wready && n < 100) begin @(negedge clk); n++; end
         @(negedge clk);
         model[8'h20 + 8'(b)] = wd[b];
      end
      i_wdata = wd[2];
      i_areset = 1'b1;
      @(negedge clk);
      i_wvalid = 1'b0;
      checks++;
      if ({o_awready, o_wready, o_bvalid, o_arready, o_rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_ctrl: got %b, want 00000", {o_awready, o_wready, o_bvalid, o_arready, o_rvalid});
      end
      @(negedge clk);
      i_areset = 1'b0;
      @(negedge clk);
      checks++;
      if (o_awready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_awready: got %b, want 1", o_awready);
      end
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (o_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_bvalid: got %b, want 0", o_bvalid);
         end
      end
      do_read(16'h0080, 1, 3'd2, 2'b01, 4'h1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) model[i] = 32'h0;
      test_reset();
      test_incr();
      test_wrap();
      test_strobe_fixed();
      test_errors();
      test_back_to_back();
      test_reset_midburst();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
